// File: rtl/mips_timer_pkg.sv
// mips_timer_pkg: register offsets, CTRL bit positions, MODE encodings and FSM states for mips_timer
package mips_timer_pkg;
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam logic [1:0] MODE_AUTO = 2'd1;
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} timer_state_t;
endpackage

// File: rtl/mips_timer.sv
// mips_timer: memory-mapped countdown timer with one-shot/auto-reload modes
// MIPS_TIMER_IRQ_EN builds the interrupt flag and irq output; otherwise irq is 0 and CTRL.IM reads 0
module mips_timer
  import mips_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);
  logic         en, im_rd, we, ctrl_we, preset_we, en_eff, unused_addr;
  logic [1:0]   mode;
  logic [31:0]  preset, count, count_nxt;
  timer_state_t state, state_nxt;
  assign hit         = addr[31:4] == BASE_ADDR[31:4];
  assign we          = hit && byteen == 4'b1111;
  assign ctrl_we     = we && addr[3:2] == OFF_CTRL;
  assign preset_we   = we && addr[3:2] == OFF_PRESET;
  assign unused_addr = ^addr[1:0];
  // a same-cycle CTRL write overrides the stored EN for LOAD/CNT decisions
  assign en_eff      = ctrl_we ? wdata[CTRL_EN] : en;
  always_comb begin
    rdata = addr[3:2] == OFF_CTRL   ? {28'd0, im_rd, mode, en} :
            addr[3:2] == OFF_PRESET ? preset :
            addr[3:2] == OFF_COUNT  ? count  : 32'd0;
  end
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: state_nxt = en ? LOAD : IDLE;
      LOAD: begin
        state_nxt = en_eff ? CNT : IDLE;
        count_nxt = en_eff ? preset : count;
      end
      CNT: begin
        state_nxt = !en_eff ? IDLE : count <= 32'd1 ? INT : CNT;
        count_nxt = !en_eff ? count : count <= 32'd1 ? 32'd0 : count - 32'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      en     <= 1'b0;
      mode   <= 2'd0;
      preset <= 32'd0;
      count  <= 32'd0;
      state  <= IDLE;
    end else begin
      en     <= ctrl_we ? wdata[CTRL_EN] : (state == INT && mode != MODE_AUTO) ? 1'b0 : en;
      mode   <= ctrl_we ? wdata[CTRL_MODE_HI:CTRL_MODE_LO] : mode;
      preset <= preset_we ? wdata : preset;
      count  <= count_nxt;
      state  <= state_nxt;
    end
  end
`ifdef MIPS_TIMER_IRQ_EN
  logic im, im_nxt, flag, flag_nxt, expire;
  assign expire   = state == CNT && en_eff && count <= 32'd1;
  assign im_nxt   = ctrl_we ? wdata[CTRL_IM] : im;
  // flag rises on entry to INT so irq is visible during the INT cycle itself
  assign flag_nxt = (ctrl_we || preset_we) ? 1'b0 : expire ? 1'b1 :
                    (state == INT && mode == MODE_AUTO) ? 1'b0 : flag;
  assign im_rd    = im;
  always_ff @(posedge clk) begin
    if (reset) begin
      im   <= 1'b0;
      flag <= 1'b0;
      irq  <= 1'b0;
    end else begin
      im   <= im_nxt;
      flag <= flag_nxt;
      irq  <= flag_nxt & im_nxt;
    end
  end
`else
  assign im_rd = 1'b0;
  assign irq   = 1'b0;
`endif
endmodule

// File: tb/tb_mips_timer.sv
// tb_mips_timer: directed and randomized checks of mips_timer against a run-length timer model
module tb_mips_timer;
  localparam logic [31:0] BASE = 32'h0000_7F00;
`ifdef MIPS_TIMER_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] addr = BASE, wdata = 32'd0;
  logic [3:0]  byteen = 4'd0;
  logic [31:0] rdata;
  logic        hit, irq;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mips_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .byteen(byteen),
    .wdata(wdata), .rdata(rdata), .hit(hit), .irq(irq)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: run = -1 idle, 0 the load cycle, n>=1 the n-th cycle after load
  bit          mv = 1'b0;
  logic        m_en, m_im, m_flag;
  logic [1:0]  m_mode;
  logic [31:0] m_pre, m_hold, m_lp;
  longint      run;
  function automatic longint r_exp();
    longint lp = longint'(m_lp);
    return lp <= 1 ? 2 : lp + 1;
  endfunction
  function automatic logic [31:0] m_count();
    longint v;
    if (run <= 0) return m_hold;
    v = longint'(m_lp) - (run - 1);
    return v < 0 ? 32'd0 : v[31:0];
  endfunction
  function automatic logic [31:0] m_rd(logic [1:0] off);
    case (off)
      2'd0:    return {28'd0, IRQ ? m_im : 1'b0, m_mode, m_en};
      2'd1:    return m_pre;
      2'd2:    return m_count();
      default: return 32'd0;
    endcase
  endfunction
  task automatic step();
    logic w, cw, pw, ee, nflag, was_int;
    if (reset) begin
      mv = 1'b1; m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
      m_pre = 0; m_hold = 0; m_lp = 0; run = -1;
      return;
    end
    if (!mv) return;
    w  = addr[31:4] == BASE[31:4] && byteen == 4'hf;
    cw = w && addr[3:2] == 2'd0;
    pw = w && addr[3:2] == 2'd1;
    ee = cw ? wdata[0] : m_en;
    was_int = run == r_exp();
    nflag = m_flag;
    if (run < 0) begin
      if (m_en) run = 0;
    end else if (was_int) begin
      run = -1; m_hold = 0;
    end else if (!ee) begin
      m_hold = m_count(); run = -1;
    end else if (run == 0) begin
      m_lp = m_pre; run = 1;
    end else run++;
    if (run == r_exp()) nflag = 1'b1;
    else if (was_int && m_mode == 2'd1) nflag = 1'b0;
    if (cw || pw) nflag = 1'b0;
    m_flag = nflag;
    m_en = cw ? wdata[0] : (was_int && m_mode != 2'd1) ? 1'b0 : m_en;
    if (cw) begin m_mode = wdata[2:1]; m_im = wdata[3]; end
    if (pw) m_pre = wdata;
  endtask
  always @(negedge clk) begin
    if (mv) begin
      chk("hit", {31'd0, hit}, {31'd0, addr[31:4] == BASE[31:4]});
      chk("rdata", rdata, m_rd(addr[3:2]));
      chk("irq", {31'd0, irq}, {31'd0, IRQ & m_flag & m_im});
    end
    step();
  end
  task automatic cyc(logic r, logic [31:0] a, logic [3:0] be, logic [31:0] d);
    @(posedge clk); #1;
    reset = r; addr = a; byteen = be; wdata = d;
  endtask
  task automatic rd(logic [3:0] off); cyc(1'b0, BASE + 32'(off), 4'h0, 32'd0); endtask
  task automatic wr(logic [3:0] off, logic [31:0] d); cyc(1'b0, BASE + 32'(off), 4'hf, d); endtask
  task automatic smp(); @(negedge clk); #1; endtask
  initial begin
    logic [31:0] a, d;
    logic [3:0]  be;
    cyc(1'b1, BASE, 4'h0, 32'd0);
    cyc(1'b1, BASE, 4'h0, 32'd0);
    for (int o = 0; o < 16; o += 4) begin
      rd(4'(o)); smp();
      chk("reset_read", rdata, 32'd0);
      chk("reset_irq", {31'd0, irq}, 32'd0);
    end
    wr(4'h4, 32'd3);
    wr(4'h0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      rd(4'h8); smp();
      if (k >= 3 && k <= 6) chk("oneshot_count", rdata, 32'(6 - k));
      chk("oneshot_irq", {31'd0, irq}, {31'd0, IRQ && k >= 6});
    end
    rd(4'h0); smp();
    chk("oneshot_ctrl", rdata, IRQ ? 32'h8 : 32'h0);
    wr(4'h0, 32'h0); smp();
    chk("irq_before_clear", {31'd0, irq}, {31'd0, IRQ});
    rd(4'h0); smp();
    chk("irq_after_clear", {31'd0, irq}, 32'd0);
    wr(4'h4, 32'd2);
    wr(4'h0, 32'hB);
    for (int k = 1; k <= 21; k++) begin
      rd(4'h8); smp();
      chk("auto_pulse", {31'd0, irq}, {31'd0, IRQ && k >= 5 && k % 5 == 0});
    end
    wr(4'h0, 32'h0);
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h1);
    for (int k = 1; k <= 7; k++) rd(4'h8);
    smp();
    chk("count_before_stop", rdata, 32'd6);
    wr(4'h0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      rd(4'h8); smp();
      chk("count_hold", rdata, 32'd5);
      chk("hold_irq", {31'd0, irq}, 32'd0);
    end
    cyc(1'b0, BASE, 4'b0001, 32'h1);
    wr(4'h8, 32'd123);
    rd(4'h0); smp();
    chk("partial_ctrl", rdata, 32'd0);
    rd(4'h8); rd(4'h8); rd(4'h8); smp();
    chk("count_ro", rdata, 32'd5);
    wr(4'h4, 32'd1);
    wr(4'h0, 32'h9);
    for (int k = 1; k <= 4; k++) rd(4'h8);
    smp();
    chk("p1_irq", {31'd0, irq}, {31'd0, IRQ});
    cyc(1'b1, BASE + 32'h8, 4'h0, 32'd0);
    for (int o = 0; o < 12; o += 4) begin
      rd(4'(o)); smp();
      chk("midrun_reset", rdata, 32'd0);
      chk("midrun_reset_irq", {31'd0, irq}, 32'd0);
    end
    for (int n = 0; n < 4000; n++) begin
      a  = BASE + {28'd0, 2'($urandom_range(0, 3)), 2'd0};
      if ($urandom_range(0, 15) == 0) a = {BASE[31:4] ^ 28'h1, 4'($urandom)};
      be = $urandom_range(0, 9) < 6 ? 4'h0 : $urandom_range(0, 9) < 8 ? 4'hf : 4'($urandom);
      d  = $urandom_range(0, 7) == 0 ? 32'($urandom) : 32'($urandom_range(0, 15));
      if (a[3:2] == 2'd0 && $urandom_range(0, 1) == 1) d = {28'd0, 1'($urandom), 2'($urandom_range(0, 1)), 1'b1};
      cyc($urandom_range(0, 999) == 0, a, be, d);
    end
    @(negedge clk); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
